// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the load/store unit.
//   lsu_state_e          - load/store unit FSM states
//   load_store_func_code - decoded memory operation from the execute stage
//   BE_WORD              - byte-enable pattern for a full word access
//   lsu_is_store()       - true for SW/SH/SB
//   lsu_is_misaligned()  - true when the address offset breaks the access size
package core_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } lsu_state_e;

    typedef enum logic [2:0] {
        LSU_LW  = 3'd0,
        LSU_LH  = 3'd1,
        LSU_LB  = 3'd2,
        LSU_LHU = 3'd3,
        LSU_LBU = 3'd4,
        LSU_SW  = 3'd5,
        LSU_SH  = 3'd6,
        LSU_SB  = 3'd7
    } load_store_func_code;

    localparam logic [3:0] BE_WORD = 4'b1111;

    function automatic logic lsu_is_store(input load_store_func_code func);
        case (func)
            LSU_SW, LSU_SH, LSU_SB: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    // Word accesses need offset 0, halfword accesses need an even offset,
    // byte accesses are always aligned.
    function automatic logic lsu_is_misaligned(input load_store_func_code func,
                                               input logic [1:0] offset);
        case (func)
            LSU_LW, LSU_SW:          return offset != 2'b00;
            LSU_LH, LSU_LHU, LSU_SH: return offset[0];
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: shifts the bus read word down to the addressed byte lane
// and sign- or zero-extends it according to the load type.
//   func_i  [2:0]  load_store_func_code of the access
//   off_i   [1:0]  byte offset within the word (address bits [1:0])
//   rdata_i [31:0] raw word from the data bus
//   data_o  [31:0] extended load result (0 for store codes)
module lsu_load_align
    import core_pkg::*;
(
    input  logic [2:0]  func_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata_i >> {off_i, 3'b000};
        data_o  = 32'h0;
        case (load_store_func_code'(func_i))
            LSU_LB:  data_o = {{24{shifted[7]}}, shifted[7:0]};
            LSU_LBU: data_o = {24'h0, shifted[7:0]};
            LSU_LH:  data_o = {{16{shifted[15]}}, shifted[15:0]};
            LSU_LHU: data_o = {16'h0, shifted[15:0]};
            LSU_LW:  data_o = shifted;
            default: data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: turns one core memory request into a single
// request/grant/response bus transaction and returns extended load data.
//   clk, rst                      clock, asynchronous active-high reset
//   lsu_req_i/func_i/addr_i/wdata_i  core request, held until done or err
//   lsu_stall_o                   freeze PC/regfile write while busy
//   lsu_done_o / lsu_err_o        one-cycle completion / misalignment pulses
//   lsu_rdata_o                   extended load data, valid with lsu_done_o
//   data_req_o/gnt_i              bus request and grant
//   data_addr_o/we_o/be_o/wdata_o bus command, stable while data_req_o is high
//   data_rvalid_i/rdata_i         bus read response
//
// Handshake: the request phase completes in the cycle where data_req_o and
// data_gnt_i are both high; until then every bus output is held stable. The
// response is accepted only in WAIT, in the first cycle data_rvalid_i is high,
// so a response arriving together with the grant or while idle is ignored.
module load_store_unit
    import core_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lsu_req_i,
    input  logic [2:0]            lsu_func_i,
    input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
    input  logic [31:0]           lsu_wdata_i,
    output logic                  lsu_stall_o,
    output logic                  lsu_done_o,
    output logic [31:0]           lsu_rdata_o,
    output logic                  lsu_err_o,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    output logic [ADDR_WIDTH-1:0] data_addr_o,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [31:0]           data_wdata_o,
    input  logic                  data_rvalid_i,
    input  logic [31:0]           data_rdata_i
);

    lsu_state_e            state_q, state_d;
    logic [2:0]            func_q;
    logic [1:0]            off_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [3:0]            be_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;

    load_store_func_code   func_in;
    logic                  misaligned;
    logic                  accept;
    logic [3:0]            be_fmt;
    logic [31:0]           wdata_fmt;
    logic [31:0]           load_data;

    assign func_in    = load_store_func_code'(lsu_func_i);
    assign misaligned = lsu_is_misaligned(func_in, lsu_addr_i[1:0]);
    assign accept     = (state_q == ST_IDLE) && lsu_req_i && !misaligned;

    // Byte enables and lane-replicated data follow the access size; loads
    // use the same enables so the bus sees which lanes are being read.
    always_comb begin
        be_fmt    = 4'b0001 << lsu_addr_i[1:0];
        wdata_fmt = {4{lsu_wdata_i[7:0]}};
        case (func_in)
            LSU_LW, LSU_SW: begin
                be_fmt    = BE_WORD;
                wdata_fmt = lsu_wdata_i;
            end
            LSU_LH, LSU_LHU, LSU_SH: begin
                be_fmt    = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_fmt = {2{lsu_wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    lsu_load_align u_align (
        .func_i  (func_q),
        .off_i   (off_q),
        .rdata_i (data_rdata_i),
        .data_o  (load_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (lsu_req_i) state_d = misaligned ? ST_ERR : ST_REQ;
            end
            ST_REQ: begin
                if (data_gnt_i) state_d = we_q ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
                if (data_rvalid_i) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            func_q  <= 3'b000;
            off_q   <= 2'b00;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                func_q  <= lsu_func_i;
                off_q   <= lsu_addr_i[1:0];
                addr_q  <= {lsu_addr_i[ADDR_WIDTH-1:2], 2'b00};
                we_q    <= lsu_is_store(func_in);
                be_q    <= be_fmt;
                wdata_q <= wdata_fmt;
                rdata_q <= 32'h0;
            end else if ((state_q == ST_WAIT) && data_rvalid_i) begin
                rdata_q <= load_data;
            end
        end
    end

    // Request and strobes decode from state so reset drops them at once.
    assign data_req_o   = (state_q == ST_REQ);
    assign data_we_o    = we_q && (state_q == ST_REQ);
    assign data_addr_o  = addr_q;
    assign data_be_o    = be_q;
    assign data_wdata_o = wdata_q;

    assign lsu_done_o   = (state_q == ST_DONE);
    assign lsu_err_o    = (state_q == ST_ERR);
    assign lsu_rdata_o  = (state_q == ST_DONE) ? rdata_q : 32'h0;
    assign lsu_stall_o  = (state_q == ST_REQ) || (state_q == ST_WAIT) ||
                          ((state_q == ST_IDLE) && lsu_req_i);

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed table of single accesses plus hand-written
// sequences for grant/rvalid delays, spurious rvalid and mid-access reset.
module tb_load_store_unit;
    import core_pkg::*;

    logic        clk;
    logic        rst;
    logic        lsu_req_i;
    logic [2:0]  lsu_func_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_wdata_i;
    logic        lsu_stall_o;
    logic        lsu_done_o;
    logic [31:0] lsu_rdata_o;
    logic        lsu_err_o;
    logic        data_req_o;
    logic        data_gnt_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .lsu_req_i     (lsu_req_i),
        .lsu_func_i    (lsu_func_i),
        .lsu_addr_i    (lsu_addr_i),
        .lsu_wdata_i   (lsu_wdata_i),
        .lsu_stall_o   (lsu_stall_o),
        .lsu_done_o    (lsu_done_o),
        .lsu_rdata_o   (lsu_rdata_o),
        .lsu_err_o     (lsu_err_o),
        .data_req_o    (data_req_o),
        .data_gnt_i    (data_gnt_i),
        .data_addr_o   (data_addr_o),
        .data_we_o     (data_we_o),
        .data_be_o     (data_be_o),
        .data_wdata_o  (data_wdata_o),
        .data_rvalid_i (data_rvalid_i),
        .data_rdata_i  (data_rdata_i)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string name);
        chk({name, "_ctl"}, {28'h0, data_req_o, data_we_o, lsu_done_o, lsu_err_o}, 32'h0);
        chk({name, "_be"},    {28'h0, data_be_o}, 32'h0);
        chk({name, "_addr"},  data_addr_o, 32'h0);
        chk({name, "_wdata"}, data_wdata_o, 32'h0);
        chk({name, "_rdata"}, lsu_rdata_o, 32'h0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0]  func;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        exp_err;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;     // 0 = not checked
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    function automatic logic bench_is_store(input logic [2:0] f);
        return (f == LSU_SW) || (f == LSU_SH) || (f == LSU_SB);
    endfunction

    // ---------------- driver / bus model ----------------
    // Runs one access; the bus grants after gnt_dly request cycles and answers
    // gnt after rv_dly WAIT cycles. spur drives a junk rvalid with the grant.
    task automatic access(input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int gnt_dly, input int rv_dly,
                          input logic spur,
                          output int lat, output logic got_err, output logic [31:0] s_addr,
                          output logic s_we, output logic [3:0] s_be, output logic [31:0] s_wdata,
                          output logic [31:0] s_rdata, output logic req_seen,
                          output logic stable, output logic stall_ok);
        int  req_cycles = 0;
        int  wait_cycles = 0;
        logic granted = 1'b0;
        lat = -1; got_err = 1'b0; s_addr = '0; s_we = 1'b0; s_be = '0; s_wdata = '0;
        s_rdata = '0; req_seen = 1'b0; stable = 1'b1; stall_ok = 1'b1;
        for (int c = 0; c < 64; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
                lsu_req_i = 1'b1; lsu_func_i = f; lsu_addr_i = a; lsu_wdata_i = wd;
            end
            data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
            if (data_req_o) begin
                data_gnt_i = (req_cycles == gnt_dly);
                if (data_gnt_i && spur) begin
                    data_rvalid_i = 1'b1; data_rdata_i = 32'h5A5A5A5A;
                end
            end else if (granted && !bench_is_store(f)) begin
                if (wait_cycles == rv_dly) begin
                    data_rvalid_i = 1'b1; data_rdata_i = rd;
                end
                wait_cycles++;
            end
            @(negedge clk);
            if (lsu_stall_o !== !(lsu_done_o || lsu_err_o)) stall_ok = 1'b0;
            if (data_req_o) begin
                if (!req_seen) begin
                    s_addr = data_addr_o; s_we = data_we_o; s_be = data_be_o; s_wdata = data_wdata_o;
                end else if ({data_addr_o, data_we_o, data_be_o, data_wdata_o} !==
                             {s_addr, s_we, s_be, s_wdata}) begin
                    stable = 1'b0;
                end
                req_seen = 1'b1;
                req_cycles++;
                if (data_gnt_i) granted = 1'b1;
            end
            if (lsu_done_o || lsu_err_o) begin
                lat = c; got_err = lsu_err_o; s_rdata = lsu_rdata_o;
                break;
            end
        end
        lsu_req_i = 1'b0;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
    endtask

    // Variables for access results
    int          r_lat;
    logic        r_err, r_we, r_req, r_stable, r_stall;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [3:0]  r_be;

    task automatic check_pulse_end(input string name);
        @(negedge clk);
        chk({name, "_pulse_end"}, {30'h0, lsu_done_o, lsu_err_o}, 32'h0);
    endtask

    initial begin
        // directed table: {func, addr, wdata, rdata, err, addr, be, wdata, rdata}
        vecs[0]  = '{LSU_LB,  32'h103, 32'h0,        32'h80FFFF12, 1'b0, 32'h100, 4'h0, 32'h0,        32'hFFFFFF80};
        vecs[1]  = '{LSU_LBU, 32'h103, 32'h0,        32'h80FFFF12, 1'b0, 32'h100, 4'h0, 32'h0,        32'h00000080};
        vecs[2]  = '{LSU_SH,  32'h102, 32'h1234ABCD, 32'h0,        1'b0, 32'h100, 4'hC, 32'hABCDABCD, 32'h0};
        vecs[3]  = '{LSU_LW,  32'h101, 32'h0,        32'h0,        1'b1, 32'h0,   4'h0, 32'h0,        32'h0};
        vecs[4]  = '{LSU_SH,  32'h103, 32'h0,        32'h0,        1'b1, 32'h0,   4'h0, 32'h0,        32'h0};
        vecs[5]  = '{LSU_LH,  32'h102, 32'h0,        32'h80017FFF, 1'b0, 32'h100, 4'h0, 32'h0,        32'hFFFF8001};
        vecs[6]  = '{LSU_LHU, 32'h102, 32'h0,        32'h80017FFF, 1'b0, 32'h100, 4'h0, 32'h0,        32'h00008001};
        vecs[7]  = '{LSU_LH,  32'h100, 32'h0,        32'h12347FFF, 1'b0, 32'h100, 4'h0, 32'h0,        32'h00007FFF};
        vecs[8]  = '{LSU_SB,  32'h101, 32'h000000A5, 32'h0,        1'b0, 32'h100, 4'h2, 32'hA5A5A5A5, 32'h0};
        vecs[9]  = '{LSU_SW,  32'h10C, 32'hCAFEF00D, 32'h0,        1'b0, 32'h10C, 4'hF, 32'hCAFEF00D, 32'h0};
        vecs[10] = '{LSU_LB,  32'h102, 32'h0,        32'h007F0000, 1'b0, 32'h100, 4'h0, 32'h0,        32'h0000007F};
        vecs[11] = '{LSU_LW,  32'h104, 32'h0,        32'h13579BDF, 1'b0, 32'h104, 4'hF, 32'h0,        32'h13579BDF};
        vecs[12] = '{LSU_LHU, 32'h101, 32'h0,        32'h0,        1'b1, 32'h0,   4'h0, 32'h0,        32'h0};
        vecs[13] = '{LSU_LB,  32'h101, 32'h0,        32'h0000FE00, 1'b0, 32'h100, 4'h0, 32'h0,        32'hFFFFFFFE};
        vecs[14] = '{LSU_SW,  32'h102, 32'h0,        32'h0,        1'b1, 32'h0,   4'h0, 32'h0,        32'h0};

        rst = 1'b1; lsu_req_i = 1'b0; lsu_func_i = 3'b0; lsu_addr_i = 32'h0; lsu_wdata_i = 32'h0;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
        #12;
        chk_zero_outputs("reset");
        chk("reset_stall", {31'h0, lsu_stall_o}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // ---- table-driven single accesses, immediate grant and rvalid ----
        for (int i = 0; i < NV; i++) begin
            string nm;
            int    exp_lat;
            nm = $sformatf("v%0d", i);
            exp_lat = vecs[i].exp_err ? 1 : (bench_is_store(vecs[i].func) ? 2 : 3);
            access(vecs[i].func, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, 0, 0, 1'b0,
                   r_lat, r_err, r_addr, r_we, r_be, r_wdata, r_rdata, r_req, r_stable, r_stall);
            chk({nm, "_err"}, {31'h0, r_err}, {31'h0, vecs[i].exp_err});
            chk({nm, "_lat"}, r_lat, exp_lat);
            chk({nm, "_stall"}, {31'h0, r_stall}, 32'h1);
            if (vecs[i].exp_err) begin
                chk({nm, "_no_req"}, {31'h0, r_req}, 32'h0);
            end else begin
                chk({nm, "_addr"}, r_addr, vecs[i].exp_addr);
                chk({nm, "_we"}, {31'h0, r_we}, {31'h0, bench_is_store(vecs[i].func)});
                if (vecs[i].exp_be != 4'h0) chk({nm, "_be"}, {28'h0, r_be}, {28'h0, vecs[i].exp_be});
                if (bench_is_store(vecs[i].func)) chk({nm, "_wdata"}, r_wdata, vecs[i].exp_wdata);
                chk({nm, "_rdata"}, r_rdata, vecs[i].exp_rdata);
            end
            check_pulse_end(nm);
        end

        // ---- LW with grant after 2 wait cycles, rvalid one cycle later ----
        access(LSU_LW, 32'h100, 32'h0, 32'hDEADBEEF, 2, 1, 1'b0,
               r_lat, r_err, r_addr, r_we, r_be, r_wdata, r_rdata, r_req, r_stable, r_stall);
        chk("lw_slow_lat", r_lat, 6);
        chk("lw_slow_addr", r_addr, 32'h100);
        chk("lw_slow_be", {28'h0, r_be}, 32'hF);
        chk("lw_slow_rdata", r_rdata, 32'hDEADBEEF);
        chk("lw_slow_stall", {31'h0, r_stall}, 32'h1);
        chk("lw_slow_stable", {31'h0, r_stable}, 32'h1);
        check_pulse_end("lw_slow");

        // ---- store with grant held off for 10 cycles ----
        access(LSU_SW, 32'h20, 32'h11223344, 32'h0, 10, 0, 1'b0,
               r_lat, r_err, r_addr, r_we, r_be, r_wdata, r_rdata, r_req, r_stable, r_stall);
        chk("gnt_hold_lat", r_lat, 12);
        chk("gnt_hold_stable", {31'h0, r_stable}, 32'h1);
        chk("gnt_hold_stall", {31'h0, r_stall}, 32'h1);
        chk("gnt_hold_wdata", r_wdata, 32'h11223344);
        chk("gnt_hold_addr", r_addr, 32'h20);
        check_pulse_end("gnt_hold");

        // ---- rvalid during the grant cycle must be ignored ----
        access(LSU_LW, 32'h40, 32'h0, 32'h0BADF00D, 0, 0, 1'b1,
               r_lat, r_err, r_addr, r_we, r_be, r_wdata, r_rdata, r_req, r_stable, r_stall);
        chk("spur_gnt_lat", r_lat, 3);
        chk("spur_gnt_rdata", r_rdata, 32'h0BADF00D);
        check_pulse_end("spur_gnt");

        // ---- reset during WAIT, then a late rvalid ----
        @(posedge clk);
        #1;
        lsu_req_i = 1'b1; lsu_func_i = LSU_LW; lsu_addr_i = 32'h200; lsu_wdata_i = 32'h0;
        @(posedge clk);
        #1 data_gnt_i = 1'b1;
        @(negedge clk);
        chk("rst_mid_req", {31'h0, data_req_o}, 32'h1);
        @(posedge clk);
        #1 data_gnt_i = 1'b0;
        @(negedge clk);
        chk("rst_mid_wait_stall", {31'h0, lsu_stall_o}, 32'h1);
        #2;
        rst = 1'b1; lsu_req_i = 1'b0;
        #1;
        chk_zero_outputs("rst_mid");
        chk("rst_mid_stall", {31'h0, lsu_stall_o}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        data_rvalid_i = 1'b1; data_rdata_i = 32'hFEEDFACE;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("late_rvalid_%0d", k), {29'h0, lsu_done_o, data_req_o, lsu_stall_o}, 32'h0);
        end
        data_rvalid_i = 1'b0; data_rdata_i = 32'h0;

        access(LSU_LW, 32'h300, 32'h0, 32'h76543210, 0, 0, 1'b0,
               r_lat, r_err, r_addr, r_we, r_be, r_wdata, r_rdata, r_req, r_stable, r_stall);
        chk("post_rst_lat", r_lat, 3);
        chk("post_rst_addr", r_addr, 32'h300);
        chk("post_rst_rdata", r_rdata, 32'h76543210);
        check_pulse_end("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit between the execute stage (ALU address, rs2 data, decoded `load_store_func_code`) and the data-memory bus. It turns one core request into a request/grant/response bus transaction, generates byte enables and replicated write data, and sign- or zero-extends load data for writeback (`READ_MEM_RESULT`). While the access is in flight it stalls the PC, and it flags misaligned addresses without issuing a bus access.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: byte address width of the core and bus.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `lsu_req_i`  in  1  access requested this cycle; held by the core until `lsu_done_o`/`lsu_err_o`.
- `lsu_func_i`  in  3  `load_store_func_code` (LW/LH/LB/LHU/LBU/SW/SH/SB).
- `lsu_addr_i`  in  ADDR_WIDTH  effective byte address (ALU result).
- `lsu_wdata_i`  in  32  store data (rs2).
- `lsu_stall_o`  out  1  freeze PC/regfile write.
- `lsu_done_o`  out  1  one-cycle pulse: access complete.
- `lsu_rdata_o`  out  32  extended load result; valid with `lsu_done_o`.
- `lsu_err_o`  out  1  one-cycle pulse: misaligned access.
- `data_req_o`  out  1  bus request.
- `data_gnt_i`  in  1  bus accepts the request this cycle.
- `data_addr_o`  out  ADDR_WIDTH  word-aligned address, bits [1:0] = 0.
- `data_we_o`  out  1  1 = write.
- `data_be_o`  out  4  byte enables.
- `data_wdata_o`  out  32  lane-replicated store data.
- `data_rvalid_i`  in  1  read data valid.
- `data_rdata_i`  in  32  read data.

## Operation
- States: IDLE, REQ, WAIT, DONE, ERR.
- IDLE:
  - `lsu_req_i` = 1 and aligned: latch func, addr[1:0], bus address, BE, and wdata; go to REQ.
  - `lsu_req_i` = 1 and misaligned: go to ERR.
- Misaligned: LW/SW with addr[1:0] ≠ 0; LH/LHU/SH with addr[0] = 1. Byte accesses are never misaligned.
- REQ: hold `data_req_o` = 1 and all bus outputs stable until `data_gnt_i`. On grant:
  - store → DONE;
  - load → WAIT.
- WAIT: on `data_rvalid_i`, register the extended data and go to DONE.
- DONE: `lsu_done_o` = 1 for one cycle, then IDLE.
- ERR: `lsu_err_o` = 1 for one cycle, then IDLE. No bus activity.
- Byte enables:
  - SW = 1111.
  - SH = 0011 when addr[1] = 0, 1100 when addr[1] = 1.
  - SB = 0001 << addr[1:0].
- Write data: SB = {4{wdata[7:0]}}, SH = {2{wdata[15:0]}}, SW = wdata.
- Load extract: `data_rdata_i` >> (8·addr[1:0]), then:
  - LB sign-extends bit 7; LBU zero-extends;
  - LH sign-extends bit 15; LHU zero-extends;
  - LW passes through.
- `lsu_rdata_o` = 0 for stores and outside DONE.
- `lsu_stall_o` = (state ≠ IDLE && state ≠ DONE && state ≠ ERR) || (state == IDLE && `lsu_req_i`). Combinational, so the core stalls in the request cycle.

## Timing
- Reset, asynchronous, takes effect immediately:
  - state = IDLE;
  - `data_req_o`, `data_we_o`, `lsu_done_o`, `lsu_err_o` = 0;
  - `data_be_o` = 0, `data_addr_o` = 0, `data_wdata_o` = 0, `lsu_rdata_o` = 0.
- Minimum latency with grant and rvalid in the first possible cycle:
  - load: request cycle T, REQ T+1 (grant), WAIT T+2 (rvalid), `lsu_done_o` T+3;
  - store: `lsu_done_o` at T+2.
- Misaligned: `lsu_err_o` at T+1.
- `data_rvalid_i` arriving during the grant cycle is not accepted; rvalid is sampled only in WAIT.
- Spurious `data_rvalid_i` in IDLE, REQ, DONE or ERR is ignored.
- At most one outstanding transaction; `lsu_req_i` is not sampled outside IDLE.
- Reset mid-transaction drops `data_req_o` in the same cycle. A late `data_rvalid_i` after reset is ignored.
- Unbounded grant or rvalid wait: the unit stalls indefinitely. There is no timeout.

## Structure
- `CORE_PKG` holds:
  - the state enum `lsu_state_e`;
  - `load_store_func_code`;
  - constant `BE_WORD` = 4'b1111.
- One natural sub-module, `lsu_load_align`: combinational shift and extend of the load data by func and addr[1:0]. The FSM, bus registers and BE/wdata formatting stay in `load_store_unit`.

## Test plan
- LW at 0x100, grant after 2 wait cycles, rvalid 1 cycle later with 0xDEADBEEF → `data_addr_o` = 0x100, BE = 1111, `lsu_done_o` pulses, `lsu_rdata_o` = 0xDEADBEEF, stall high throughout.
- LB at 0x103 and LBU at 0x103, rdata 0x80FF_FF12 → `lsu_rdata_o` = 0xFFFFFF80 and 0x00000080; `data_addr_o` = 0x100.
- SH at 0x102, wdata 0x1234ABCD → `data_we_o` = 1, BE = 1100, `data_wdata_o` = 0xABCDABCD, done at T+2 with immediate grant, no rvalid needed.
- LW at 0x101 and SH at 0x103 → `lsu_err_o` pulses at T+1, `data_req_o` never asserted, back to IDLE.
- Reset asserted during WAIT of a load, rvalid then arrives → outputs zero immediately, no `lsu_done_o`, next LW completes normally.
- Hold `data_gnt_i` low 10 cycles → `data_req_o`, address, BE and wdata stable all 10 cycles; `lsu_stall_o` remains 1.
